bec_csla_seq_addsub: RTL and testbench

BEC_CSLA_SEQ_ADDSUB -- requirements
Module: bec_csla_seq_addsub

---
 rtl/bec_csla_pkg.sv | 13 +
 rtl/bec_csla_slice.sv | 37 +++
 rtl/bec_csla_seq_addsub.sv | 127 ++++++++++++
 tb/tb_bec_csla_seq_addsub.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_csla_pkg.sv
// Shared constants and FSM state encoding for the sequential carry-select adder/subtractor.
package bec_csla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bec_csla_slice.sv
// One SLICE-bit carry-select stage: a ripple sum for carry-in 0, a binary-to-excess-1
// converter that derives the carry-in 1 sum from it, and a mux on the incoming carry.
module bec_csla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0]   rc;
  logic [SLICE:0]   ones;
  logic [SLICE-1:0] s0;
  logic [SLICE-1:0] s1;

  assign rc[0]   = 1'b0;
  assign ones[0] = 1'b1;

  // ones[i] is high when s0[i-1:0] is all ones, i.e. +1 toggles bit i
  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign s0[gi]      = a[gi] ^ b[gi] ^ rc[gi];
      assign rc[gi+1]    = (a[gi] & b[gi]) | (rc[gi] & (a[gi] ^ b[gi]));
      assign s1[gi]      = s0[gi] ^ ones[gi];
      assign ones[gi+1]  = ones[gi] & s0[gi];
    end
  endgenerate

  assign s     = cin ? s1 : s0;
  assign cout  = cin ? (rc[SLICE] | ones[SLICE]) : rc[SLICE];
  // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c
  assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];

endmodule

// File: rtl/bec_csla_seq_addsub.sv
// Sequential add/subtract, one carry-select slice per cycle over WIDTH/SLICE cycles.
// Subtraction is enabled by defining BEC_CSLA_SUB_EN; otherwise op is ignored.
module bec_csla_seq_addsub
  import bec_csla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_cfg
      $error("WIDTH must be a positive integer multiple of SLICE");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg, ovf_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              sub_op;
  logic              accept;

  logic [SLICE-1:0]  sl_a, sl_b, sl_s;
  logic              sl_cout, sl_cmsb;

`ifdef BEC_CSLA_SUB_EN
  assign sub_op = op;
`else
  logic unused_op;
  assign unused_op = op;
  assign sub_op    = 1'b0;
`endif

  assign sl_a = a_reg[idx_reg*SLICE +: SLICE];
  assign sl_b = b_reg[idx_reg*SLICE +: SLICE];

  bec_csla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_reg),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      // Subtract as a + ~b + 1, the +1 entering as the first slice's carry-in
      a_reg     <= a;
      b_reg     <= sub_op ? ~b : b;
      carry_reg <= sub_op;
      idx_reg   <= '0;
    end else if (state_reg == CALC) begin
      sum_reg[idx_reg*SLICE +: SLICE] <= sl_s;
      carry_reg                       <= sl_cout;
      if (idx_reg == LAST_IDX) begin
        cout_reg <= sl_cout;
        ovf_reg  <= sl_cout ^ sl_cmsb;
        idx_reg  <= '0;
      end else begin
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bec_csla_seq_addsub.sv
// Scoreboard bench for bec_csla_seq_addsub (32-bit, 8-bit slices).
module tb_bec_csla_seq_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op;
  logic        out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [33:0] exp_q[$];

`ifdef BEC_CSLA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  bec_csla_seq_addsub #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {cout, ovf, sum}; overflow from the operand/result sign rule
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic        s;
    logic [31:0] yb;
    logic [32:0] t;
    logic        v;
    s  = SUB_EN ? o : 1'b0;
    yb = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yb} + 33'(s);
    v  = (x[31] == yb[31]) && (t[31] != x[31]);
    return {t[32], v, t[31:0]};
  endfunction

  // Presents an operand pair, pushes its expectation, returns #1 after the accept edge
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                      input logic [33:0] e);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    op       = top;
    exp_q.push_back(e);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit timed_out);
    cyc       = 0;
    timed_out = 1'b1;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #2;
    n_vec++;
    if ({in_ready, out_valid, cout, ovf} !== 4'b1000 || sum !== 32'h0) begin
      n_miss++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 00000000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va[7] = '{32'h00000000, 32'h56745675, 32'hAB674594, 32'hFFFFFFFF,
                           32'h00000005, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb[7] = '{32'h00000000, 32'h54546576, 32'hAC784387, 32'h00000001,
                           32'h00000007, 32'h00000001, 32'h80000000};
    logic        vo[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [33:0] ve[7];
    logic [33:0] e;
    int          cyc;
    bit          to;
    ve[0] = {1'b0, 1'b0, 32'h00000000};
    ve[1] = {1'b0, 1'b1, 32'hAAC8BBEB};
    ve[2] = {1'b1, 1'b1, 32'h57DF891B};
    ve[3] = {1'b1, 1'b0, 32'h00000000};
    ve[4] = SUB_EN ? {1'b0, 1'b0, 32'hFFFFFFFE} : {1'b0, 1'b0, 32'h0000000C};
    ve[5] = {1'b0, 1'b1, 32'h80000000};
    ve[6] = {1'b1, 1'b1, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i], vo[i], ve[i]);
      wait_out(cyc, to);
      n_vec++;
      if (to) begin
        n_miss++;
        $display("FAIL directed[%0d] timeout: out_valid=0 required 1", i);
        void'(exp_q.pop_front());
        continue;
      end
      e = exp_q.pop_front();
      $display("txn directed[%0d] a=%h b=%h op=%b sum=%h cout=%b ovf=%b lat=%0d",
               i, va[i], vb[i], vo[i], sum, cout, ovf, cyc);
      if (sum !== e[31:0] || cout !== e[33] || ovf !== e[32] || cyc != 4) begin
        n_miss++;
        $display("FAIL directed[%0d]: sum=%h cout=%b ovf=%b lat=%0d required %h %b %b 4",
                 i, sum, cout, ovf, cyc, e[31:0], e[33], e[32]);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic        ro;
    logic [33:0] e;
    int          cyc;
    bit          to;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; ro = 1'($urandom_range(0, 1));
      send(ra, rb, ro, model(ra, rb, ro));
      wait_out(cyc, to);
      n_vec++;
      if (to) begin
        n_miss++;
        $display("FAIL random[%0d] timeout: out_valid=0 required 1", i);
        void'(exp_q.pop_front());
        continue;
      end
      e = exp_q.pop_front();
      $display("txn random[%0d] a=%h b=%h op=%b sum=%h cout=%b ovf=%b", i, ra, rb, ro, sum, cout, ovf);
      if (sum !== e[31:0] || cout !== e[33] || ovf !== e[32]) begin
        n_miss++;
        $display("FAIL random[%0d]: sum=%h cout=%b ovf=%b required %h %b %b",
                 i, sum, cout, ovf, e[31:0], e[33], e[32]);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [33:0] e;
    int          cyc;
    bit          to;
    bit          seen;
    send(32'h12345678, 32'h0F0F0F0F, 1'b1, model(32'h12345678, 32'h0F0F0F0F, 1'b1));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to) begin
      n_miss++;
      $display("FAIL hold timeout: out_valid=0 required 1");
      return;
    end
    $display("txn hold a=12345678 b=0f0f0f0f sum=%h cout=%b ovf=%b", sum, cout, ovf);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = ~op;
      @(posedge clk); #1;
      n_vec++;
      if (sum !== e[31:0] || cout !== e[33] || ovf !== e[32] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_miss++;
        $display("FAIL hold[%0d]: sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b required %h %b %b 0 1",
                 k, sum, cout, ovf, in_ready, out_valid, e[31:0], e[33], e[32]);
      end
    end
    in_valid = 1'b0;
    consume();
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen || in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL hold_no_second_accept: spurious out_valid=%b in_ready=%b required 0 1", seen, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [33:0] e;
    int          cyc;
    bit          to;
    bit          seen;
    send(32'hDEADBEEF, 32'h01234567, 1'b0, 34'h0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, cout, ovf} !== 4'b1000 || sum !== 32'h0) begin
      n_miss++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 00000000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_miss++;
      $display("FAIL mid_reset_discard: out_valid seen=1 required 0");
    end
    send(32'h89ABCDEF, 32'h76543211, 1'b0, model(32'h89ABCDEF, 32'h76543211, 1'b0));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || sum !== e[31:0] || cout !== e[33] || ovf !== e[32]) begin
      n_miss++;
      $display("FAIL after_reset: timeout=%b sum=%h cout=%b ovf=%b required 0 %h %b %b",
               to, sum, cout, ovf, e[31:0], e[33], e[32]);
    end
    $display("txn after_reset a=89abcdef b=76543211 sum=%h cout=%b ovf=%b", sum, cout, ovf);
    if (!to) consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rb;
    logic        ro;
    logic [33:0] e;
    int          cyc;
    bit          to;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; ro = 1'($urandom_range(0, 1));
      send(ra, rb, ro, model(ra, rb, ro));
      wait_out(cyc, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || in_ready !== 1'b0 || sum !== e[31:0] || cout !== e[33] || ovf !== e[32]) begin
        n_miss++;
        $display("FAIL b2b[%0d]: timeout=%b in_ready=%b sum=%h cout=%b ovf=%b required 0 0 %h %b %b",
                 i, to, in_ready, sum, cout, ovf, e[31:0], e[33], e[32]);
      end
      $display("txn b2b[%0d] a=%h b=%h op=%b sum=%h cout=%b ovf=%b", i, ra, rb, ro, sum, cout, ovf);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
